adbg_module_select: RTL and testbench
=====================================

// Module: adbg_module_select
// PURPOSE
//  Parametrised top-level chain selector for the advanced debug interface.
//  - Shifts the JTAG debug DR and latches a module ID on select commands.
//  - Drives one-hot selects to NB_MODULES debug sub-modules and muxes their TDO.
//  - Successor of the fixed two-module selector; adds ID validation, an enable
//    mask, a sticky select-error flag and a readable status chain.
// PARAMETERS
//  NB_MODULES  4          number of attached debug sub-modules (1..2**ID_WIDTH)
//  DATA_LEN    64         input shift register length (>= ID_WIDTH+2)
//  ID_WIDTH    5          module ID field width
//  MODULE_EN   '1         NB_MODULES-bit mask; bit i=0 makes ID i unselectable
// PORTS
//  tck_i            in   1               JTAG TCK; only clock
//  rst_i            in   1               synchronous reset, active-high
//  tdi_i            in   1               JTAG TDI
//  tdo_o            out  1               JTAG TDO (combinational mux)
//  shift_dr_i       in   1               TAP Shift-DR
//  capture_dr_i     in   1               TAP Capture-DR
//  update_dr_i      in   1               TAP Update-DR
//  debug_select_i   in   1               debug instruction active in IR
//  data_register_o  out  DATA_LEN        input shift register, to sub-modules
//  module_select_o  out  NB_MODULES      one-hot select; all-zero when invalid
//  module_inhibit_i in   NB_MODULES      sub-module busy; blocks reselection
//  module_tdo_i     in   NB_MODULES      per-module TDO
//  sel_err_o        out  1               sticky: last select command was rejected
// BEHAVIOUR
//  - All state updates on posedge tck_i.
//  - rst_i has priority. Reset values:
//    - shift reg = 0, id_reg = 0, sel_valid = 1, sel_err_o = 0, status_sr = 0.
//    - module_select_o = 1 (module 0 selected), as in the previous generation.
//  - Shift: when debug_select_i & shift_dr_i, sr <= {tdi_i, sr[DATA_LEN-1:1]}.
//  - Decode: select_cmd = sr[DATA_LEN-1]; id_in = sr[DATA_LEN-2 -: ID_WIDTH].
//  - Select: acts when debug_select_i & update_dr_i & select_cmd. Uses the sr
//    value before any same-cycle shift.
//    - |module_inhibit_i: command ignored; id, valid and err unchanged.
//    - id_in < NB_MODULES & MODULE_EN[id_in]: id_reg <= id_in, sel_valid <= 1,
//      sel_err_o <= 0.
//    - otherwise: id_reg <= id_in (kept for diagnosis), sel_valid <= 0,
//      sel_err_o <= 1.
//    - select_cmd = 0: no top-level effect; the data is for the selected module.
//  - module_select_o is registered:
//    - one-hot at bit id_reg when sel_valid;
//    - all zero when not sel_valid.
//    - Changes the cycle after the Update-DR edge.
//  - Status chain (active only when !sel_valid):
//    - On debug_select_i & capture_dr_i: status_sr <= {sel_err_o, sel_valid, id_reg}
//      (ID_WIDTH+2 bits).
//    - On shift: status_sr shifts right, MSB filled with 0.
//    - If capture and shift are asserted together, capture wins.
//  - tdo_o: module_tdo_i[id_reg] when sel_valid, else status_sr[0].
//    - Combinational, zero latency.
//  - Reset mid-shift or mid-select: everything returns to reset values on the
//    next edge; a pending update is discarded.
// TESTING
//  - Reset: rst_i=1 for 2 cycles -> module_select_o=4'b0001, sel_err_o=0,
//    tdo_o follows module_tdo_i[0].
//  - Shift 64 bits with MSB=1, id=2, then update -> next cycle
//    module_select_o=4'b0100; tdo_o follows module_tdo_i[2].
//  - Select id=5 (NB_MODULES=4) -> module_select_o=0, sel_err_o=1.
//    Capture then shift 7 bits -> tdo_o sequence 1,0,1,0,0,0,1.
//  - module_inhibit_i=4'b0010 during select id=3 -> selection stays at id 2,
//    sel_err_o unchanged.
//  - MODULE_EN=4'b1011, select id=2 -> rejected, sel_err_o=1.
//    Then select id=1 -> module_select_o=4'b0010, sel_err_o=0.
//  - Update with select_cmd=0 -> no change. rst_i asserted mid-shift ->
//    next cycle data_register_o=0, module_select_o=4'b0001.

Source files
------------

// File: rtl/adbg_module_select.sv
// Top-level debug chain selector: shifts the debug DR, latches and validates a module ID,
// drives one-hot sub-module selects and muxes TDO (sub-module or status chain).
module adbg_module_select #(
  parameter int                    NB_MODULES = 4,
  parameter int                    DATA_LEN   = 64,
  parameter int                    ID_WIDTH   = 5,
  parameter logic [NB_MODULES-1:0] MODULE_EN  = '1
) (
  input  logic                  tck_i,
  input  logic                  rst_i,
  input  logic                  tdi_i,
  output logic                  tdo_o,
  input  logic                  shift_dr_i,
  input  logic                  capture_dr_i,
  input  logic                  update_dr_i,
  input  logic                  debug_select_i,
  output logic [DATA_LEN-1:0]   data_register_o,
  output logic [NB_MODULES-1:0] module_select_o,
  input  logic [NB_MODULES-1:0] module_inhibit_i,
  input  logic [NB_MODULES-1:0] module_tdo_i,
  output logic                  sel_err_o
);
  localparam int NID = 2**ID_WIDTH;

  logic [DATA_LEN-1:0]   r_sr;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_valid;
  logic                  r_err;
  logic [ID_WIDTH+1:0]   r_status;
  logic [NB_MODULES-1:0] r_sel;

  logic                  w_cmd;
  logic [ID_WIDTH-1:0]   w_id_in;
  logic [NID-1:0]        w_en_full;
  logic [NID-1:0]        w_tdo_full;
  logic                  w_do_sel;
  logic [ID_WIDTH-1:0]   w_id_nxt;
  logic                  w_valid_nxt;
  logic                  w_err_nxt;
  logic [NB_MODULES-1:0] w_sel_nxt;

  assign w_cmd    = r_sr[DATA_LEN-1];
  assign w_id_in  = r_sr[DATA_LEN-2 -: ID_WIDTH];
  assign w_do_sel = debug_select_i & update_dr_i & w_cmd & ~(|module_inhibit_i);

  // Zero-extended to the full ID space so any id_in indexes safely.
  always_comb begin
    w_en_full                   = '0;
    w_en_full[NB_MODULES-1:0]   = MODULE_EN;
    w_tdo_full                  = '0;
    w_tdo_full[NB_MODULES-1:0]  = module_tdo_i;
  end

  always_comb begin
    w_id_nxt    = r_id;
    w_valid_nxt = r_valid;
    w_err_nxt   = r_err;
    if (w_do_sel) begin
      w_id_nxt    = w_id_in;
      w_valid_nxt = w_en_full[w_id_in];
      w_err_nxt   = ~w_en_full[w_id_in];
    end
    for (int i = 0; i < NB_MODULES; i++)
      w_sel_nxt[i] = w_valid_nxt && (w_id_nxt == ID_WIDTH'(i));
  end

  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      r_sr     <= '0;
      r_id     <= '0;
      r_valid  <= 1'b1;
      r_err    <= 1'b0;
      r_status <= '0;
      r_sel    <= NB_MODULES'(1);
    end else begin
      if (debug_select_i & shift_dr_i)
        r_sr <= {tdi_i, r_sr[DATA_LEN-1:1]};
      r_id    <= w_id_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_sel   <= w_sel_nxt;
      // Status chain only owns TDO while no valid module is selected.
      if (!r_valid && debug_select_i) begin
        if (capture_dr_i)
          r_status <= {r_err, r_valid, r_id};
        else if (shift_dr_i)
          r_status <= {1'b0, r_status[ID_WIDTH+1:1]};
      end
    end
  end

  assign tdo_o           = r_valid ? w_tdo_full[r_id] : r_status[0];
  assign data_register_o = r_sr;
  assign module_select_o = r_sel;
  assign sel_err_o       = r_err;
endmodule

// File: tb/tb_adbg_module_select.sv
// Bench for adbg_module_select: table of select commands on two instances
// (all modules enabled / MODULE_EN=4'b1011), plus status-chain and reset sequences.
module tb_adbg_module_select;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, tdi, shift, cap, upd, dsel;
  logic [3:0] inh, mtdo;
  logic tdoA, tdoB, errA, errB;
  logic [63:0] drA, drB;
  logic [3:0] selA, selB;

  adbg_module_select #(.NB_MODULES(4), .DATA_LEN(64), .ID_WIDTH(5), .MODULE_EN(4'b1111)) dutA (
    .tck_i(clk), .rst_i(rst), .tdi_i(tdi), .tdo_o(tdoA), .shift_dr_i(shift),
    .capture_dr_i(cap), .update_dr_i(upd), .debug_select_i(dsel),
    .data_register_o(drA), .module_select_o(selA), .module_inhibit_i(inh),
    .module_tdo_i(mtdo), .sel_err_o(errA));

  adbg_module_select #(.NB_MODULES(4), .DATA_LEN(64), .ID_WIDTH(5), .MODULE_EN(4'b1011)) dutB (
    .tck_i(clk), .rst_i(rst), .tdi_i(tdi), .tdo_o(tdoB), .shift_dr_i(shift),
    .capture_dr_i(cap), .update_dr_i(upd), .debug_select_i(dsel),
    .data_register_o(drB), .module_select_o(selB), .module_inhibit_i(inh),
    .module_tdo_i(mtdo), .sel_err_o(errB));

  typedef struct {
    logic [4:0] id;
    logic       cmd;
    logic [3:0] inh;
    logic [3:0] selA;
    logic       errA;
    logic [3:0] selB;
    logic       errB;
  } vec_t;

  vec_t        tbl[8];
  logic [63:0] sb[$];
  int          tests = 0, fails = 0;

  task automatic push(input logic [63:0] e);
    sb.push_back(e);
  endtask

  task automatic cmp(input string nm, input logic [63:0] act);
    logic [63:0] e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, got %0h", nm, act);
    end else begin
      e = sb.pop_front();
      if (act !== e) begin
        fails++;
        $display("FAIL %s: got %0h expected %0h", nm, act, e);
      end
    end
  endtask

  task automatic shift_word(input logic [63:0] w);
    for (int i = 0; i < 64; i++) begin
      shift = 1'b1; tdi = w[i];
      @(posedge clk); #1;
    end
    shift = 1'b0; tdi = 1'b0;
  endtask

  task automatic do_select(input logic [4:0] id, input logic c, input logic [3:0] ih,
                           input logic [3:0] eSA, input logic eEA,
                           input logic [3:0] eSB, input logic eEB);
    logic [63:0] w;
    w = {32'h0, $urandom};
    w[63] = c;
    w[62:58] = id;
    shift_word(w);
    @(negedge clk);
    push(w); cmp("data_register", drA);
    push({60'h0, eSA}); push({63'h0, eEA}); push({60'h0, eSB}); push({63'h0, eEB});
    inh = ih; upd = 1'b1;
    @(posedge clk); #1;
    upd = 1'b0; inh = 4'b0;
    @(negedge clk);
    cmp("selA", {60'h0, selA}); cmp("errA", {63'h0, errA});
    cmp("selB", {60'h0, selB}); cmp("errB", {63'h0, errB});
    if (eSA != 4'b0) begin
      mtdo = eSA;  #1; push(64'd1); cmp("tdoA_hi", {63'h0, tdoA});
      mtdo = ~eSA; #1; push(64'd0); cmp("tdoA_lo", {63'h0, tdoA});
    end
  endtask

  initial begin
    logic [6:0] st;
    rst = 1'b1; tdi = 0; shift = 0; cap = 0; upd = 0; dsel = 1'b1; inh = 0; mtdo = 0;
    //          id   cmd  inh      selA     errA selB     errB
    tbl[0] = '{5'd2,  1'b1, 4'b0000, 4'b0100, 1'b0, 4'b0000, 1'b1};
    tbl[1] = '{5'd3,  1'b1, 4'b0010, 4'b0100, 1'b0, 4'b0000, 1'b1};
    tbl[2] = '{5'd1,  1'b1, 4'b0000, 4'b0010, 1'b0, 4'b0010, 1'b0};
    tbl[3] = '{5'd3,  1'b0, 4'b0000, 4'b0010, 1'b0, 4'b0010, 1'b0};
    tbl[4] = '{5'd31, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1};
    tbl[5] = '{5'd0,  1'b1, 4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b0};
    tbl[6] = '{5'd3,  1'b1, 4'b0000, 4'b1000, 1'b0, 4'b1000, 1'b0};
    tbl[7] = '{5'd5,  1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    push(64'd1); cmp("rst_selA", {60'h0, selA});
    push(64'd0); cmp("rst_errA", {63'h0, errA});
    push(64'd0); cmp("rst_dr",   drA);
    mtdo = 4'b0001; #1; push(64'd1); cmp("rst_tdo_hi", {63'h0, tdoA});
    mtdo = 4'b1110; #1; push(64'd0); cmp("rst_tdo_lo", {63'h0, tdoA});

    for (int i = 0; i < 8; i++)
      do_select(tbl[i].id, tbl[i].cmd, tbl[i].inh, tbl[i].selA, tbl[i].errA,
                tbl[i].selB, tbl[i].errB);

    // Status chain after rejected id 5: {err=1, valid=0, id=5}, LSB out first.
    st = {1'b1, 1'b0, 5'd5};
    @(posedge clk); #1 cap = 1'b1;
    @(posedge clk); #1 cap = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      push({63'h0, st[k]}); cmp("status_bit", {63'h0, tdoA});
      shift = 1'b1;
      @(posedge clk); #1 shift = 1'b0;
    end

    // Reset in the middle of a shift.
    for (int i = 0; i < 20; i++) begin
      shift = 1'b1; tdi = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1; upd = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; shift = 1'b0; upd = 1'b0; tdi = 1'b0;
    @(negedge clk);
    push(64'd0); cmp("midrst_dr",   drA);
    push(64'd1); cmp("midrst_selA", {60'h0, selA});
    push(64'd0); cmp("midrst_errA", {63'h0, errA});
    push(64'd1); cmp("midrst_selB", {60'h0, selB});
    mtdo = 4'b0001; #1; push(64'd1); cmp("midrst_tdo_hi", {63'h0, tdoA});
    mtdo = 4'b1110; #1; push(64'd0); cmp("midrst_tdo_lo", {63'h0, tdoA});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
